// File: rtl/alarm_controller.sv
// alarm_controller: holds a programmed 12-hour alarm time, rings when the
// running time reaches it, and handles stop, snooze and ring timeout.
//
// Configuration macro: ALARM_SNOOZE_LIMIT_EN
//   defined   - snooze is refused once MAX_SNOOZE snoozes have been taken
//               in the current alarm event.
//   undefined - snooze is always accepted; the snooze counter saturates at 7.
//
// Control inputs (set_alarm, stop, snooze) are single-cycle strobes and
// are acted on in the cycle they are high; there is no handshake.
// All responses appear on the clk edge following the causing input.
`timescale 1ns/1ps
module alarm_controller #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 9,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       pm,
  input  logic       arm_en,
  input  logic       set_alarm,
  input  logic [3:0] set_hour,
  input  logic [5:0] set_min,
  input  logic       set_pm,
  input  logic       stop,
  input  logic       snooze,
  output logic [3:0] al_hour,
  output logic [5:0] al_min,
  output logic       al_pm,
  output logic       ringing,
  output logic       armed,
  output logic       snoozing,
  output logic [2:0] snooze_cnt,
  output logic       set_err
);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam logic [2:0] SNZ_CAP = 3'(MAX_SNOOZE);
`else
  // Without the limit the counter simply saturates at full scale.
  localparam logic [2:0] SNZ_CAP = 3'(MAX_SNOOZE) | 3'b111;
`endif

  state_t     state, state_n;
  logic [7:0] ring_cnt, ring_cnt_n;
  logic [2:0] snooze_cnt_n;
  logic [3:0] snz_hour;
  logic [5:0] snz_min;
  logic       snz_pm;
  logic       match, match_q, trig;
  logic       set_ok, load_ok, load_bad;
  logic       snz_allow, snz_take;
  logic [3:0] tgt_hour;
  logic [5:0] tgt_min;
  logic       tgt_pm;
  logic [6:0] m_sum;
  logic [3:0] nx_hour;
  logic [5:0] nx_min;
  logic       nx_pm;

  // State is exposed directly through the status outputs.
  assign ringing  = (state == RINGING);
  assign armed    = (state != IDLE);
  assign snoozing = (state == SNOOZE);

  assign set_ok   = (set_hour >= 4'd1) && (set_hour <= 4'd12) && (set_min <= 6'd59);
  assign load_ok  = set_alarm & set_ok;
  assign load_bad = set_alarm & ~set_ok;

`ifdef ALARM_SNOOZE_LIMIT_EN
  assign snz_allow = (snooze_cnt != SNZ_CAP);
`else
  assign snz_allow = 1'b1;
`endif

  // Compare target: alarm time normally, snooze target while snoozing.
  always_comb begin
    tgt_hour = al_hour;
    tgt_min  = al_min;
    tgt_pm   = al_pm;
    if (state == SNOOZE) begin
      tgt_hour = snz_hour;
      tgt_min  = snz_min;
      tgt_pm   = snz_pm;
    end
  end

  assign match = (hour == tgt_hour) && (min == tgt_min) && (pm == tgt_pm) && (sec == 6'd0);
  assign trig  = match & ~match_q;

  // Snooze target = now + SNOOZE_MIN minutes with 12-hour / meridiem rollover.
  always_comb begin
    m_sum   = {1'b0, min} + 7'(SNOOZE_MIN);
    nx_min  = m_sum[5:0];
    nx_hour = hour;
    nx_pm   = pm;
    if (m_sum >= 7'd60) begin
      nx_min = 6'(m_sum - 7'd60);
      if (hour == 4'd12) begin
        nx_hour = 4'd1;
      end else if (hour == 4'd11) begin
        nx_hour = 4'd12;
        nx_pm   = ~pm;
      end else begin
        nx_hour = hour + 4'd1;
      end
    end
  end

  // Next-state logic: arm_en=0 > set_alarm > stop > snooze > trig/timeout.
  always_comb begin
    state_n      = state;
    ring_cnt_n   = ring_cnt;
    snooze_cnt_n = snooze_cnt;
    snz_take     = 1'b0;
    if (!arm_en) begin
      state_n      = IDLE;
      snooze_cnt_n = 3'd0;
    end else if (state == IDLE) begin
      state_n      = ARMED;
      snooze_cnt_n = 3'd0;
    end else if (set_alarm) begin
      if (set_ok && (state == RINGING || state == SNOOZE)) begin
        state_n      = ARMED;
        snooze_cnt_n = 3'd0;
      end
    end else begin
      case (state)
        ARMED: begin
          if (trig) begin
            state_n    = RINGING;
            ring_cnt_n = 8'd0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_n      = ARMED;
            snooze_cnt_n = 3'd0;
          end else if (snooze && snz_allow) begin
            state_n      = SNOOZE;
            snz_take     = 1'b1;
            snooze_cnt_n = (snooze_cnt == SNZ_CAP) ? snooze_cnt : snooze_cnt + 3'd1;
          end else if (tick) begin
            if (ring_cnt == RING_LAST) begin
              state_n      = ARMED;
              snooze_cnt_n = 3'd0;
            end else begin
              ring_cnt_n = ring_cnt + 8'd1;
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_n      = ARMED;
            snooze_cnt_n = 3'd0;
          end else if (trig) begin
            state_n    = RINGING;
            ring_cnt_n = 8'd0;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // State, counters, alarm and snooze-target registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      al_hour    <= 4'd12;
      al_min     <= 6'd0;
      al_pm      <= 1'b0;
      snz_hour   <= 4'd12;
      snz_min    <= 6'd0;
      snz_pm     <= 1'b0;
      ring_cnt   <= 8'd0;
      snooze_cnt <= 3'd0;
      match_q    <= 1'b0;
      set_err    <= 1'b0;
    end else begin
      state      <= state_n;
      ring_cnt   <= ring_cnt_n;
      snooze_cnt <= snooze_cnt_n;
      match_q    <= match;
      set_err    <= load_bad;
      if (load_ok) begin
        al_hour <= set_hour;
        al_min  <= set_min;
        al_pm   <= set_pm;
      end
      if (snz_take) begin
        snz_hour <= nx_hour;
        snz_min  <= nx_min;
        snz_pm   <= nx_pm;
      end
    end
  end

endmodule
